// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller.
//   nibble_t : one hex digit value
//   BLANK    : active-low segment pattern with every segment dark
//   HEX_PAT  : active-low {a,b,c,d,e,f,g,dp} patterns for hex digits 0..F,
//              decimal point always dark
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [7:0] BLANK = 8'hFF;

    localparam logic [7:0] HEX_PAT [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D,
        8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1,
        8'h63, 8'h85, 8'h61, 8'h71
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
// Display-word handshake into the scan controller.
//   in_valid : producer offers a new display word
//   in_ready : controller can take a word (nothing pending)
//   in_data  : hex nibbles, digit k at bits [4k+3:4k]
//   in_mask  : per-digit enable, 0 forces that digit blank
// Modports: master = word producer, slave = scan controller.
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
    parameter int NDIG = 8
);

    logic                in_valid;
    logic                in_ready;
    logic [4*NDIG-1:0]   in_data;
    logic [NDIG-1:0]     in_mask;

    modport master (
        output in_valid,
        output in_data,
        output in_mask,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mask,
        output in_ready
    );

endinterface

// File: rtl/seg_hex_rom.sv
// ---------------------------------------------------------------------------
// seg_hex_rom
// Combinational hex-to-segment decoder.
//   nibble  : hex digit to show
//   en      : 1 = show the digit, 0 = blank
//   pattern : active-low {a,b,c,d,e,f,g,dp}, BLANK when disabled
// ---------------------------------------------------------------------------
module seg_hex_rom
    import seg_pkg::*;
(
    input  nibble_t    nibble,
    input  logic       en,
    output logic [7:0] pattern
);

    // Table lookup from the shared package; a disabled digit stays dark.
    always_comb begin
        pattern = BLANK;
        if (en) begin
            pattern = HEX_PAT[nibble];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed driver for NDIG seven-segment digits with a tear-free
// double-buffered display word.
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   bus        : seg_scan_ctrl_if.slave word handshake (valid/ready/data/mask)
//   an         : active-low digit select, registered, at most one bit low
//   seg        : active-low segments {a..g,dp}, registered, 8'hFF = blank
//   frame_done : one-cycle pulse the cycle after each frame boundary
// Parameters: DIV  = clk cycles per digit slot (>= 2)
//             NDIG = number of digits (1..8)
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digits above the highest-index nonzero masked-on nibble; digit 0 never).
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int NDIG = 8
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_ctrl_if.slave    bus,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        seg,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d;
    logic [4*NDIG-1:0]  pend_val_q, pend_val_d;
    logic [NDIG-1:0]    pend_mask_q, pend_mask_d;
    logic [4*NDIG-1:0]  disp_val_q, disp_val_d;
    logic [NDIG-1:0]    disp_mask_q, disp_mask_d;
    logic               frame_done_q, frame_done_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic [7:0]         seg_q, seg_d;

    logic               tick;
    logic               boundary;
    logic               accept;
    logic [NDIG-1:0]    lz_blank;
    nibble_t            cur_nib;
    logic               cur_en;
    logic [7:0]         rom_pat;

    assign bus.in_ready = !pending_q;
    assign an           = an_q;
    assign seg          = seg_q;
    assign frame_done   = frame_done_q;

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; every digit above the first nonzero
    // masked-on nibble is a leading zero. Digit 0 is always left alone so an
    // all-zero value still shows a single "0".
    logic lz_seen;
    always_comb begin
        lz_blank = '0;
        lz_seen  = 1'b0;
        for (int k = NDIG - 1; k >= 1; k--) begin
            if (disp_mask_q[k] && (disp_val_q[4*k +: 4] != 4'h0)) begin
                lz_seen = 1'b1;
            end
            lz_blank[k] = !lz_seen;
        end
    end
`else
    // Leading-zero suppression disabled: the mask alone decides.
    always_comb begin
        lz_blank = '0;
    end
`endif

    // Select the nibble and lit state of the digit currently being scanned,
    // and build the matching one-cold anode pattern.
    always_comb begin
        cur_nib = '0;
        cur_en  = 1'b0;
        an_d    = '1;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib  = disp_val_q[4*k +: 4];
                cur_en   = disp_mask_q[k] && !lz_blank[k];
                an_d[k]  = !(disp_mask_q[k] && !lz_blank[k]);
            end
        end
    end

    seg_hex_rom u_hex_rom (
        .nibble  (cur_nib),
        .en      (cur_en),
        .pattern (rom_pat)
    );

    // Next-state logic: prescaler, digit index, input buffer and display
    // buffer. The display buffer only changes at a frame boundary, and only
    // from a word that was already pending before that cycle, so a frame is
    // never drawn from two different words.
    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        boundary = tick && (idx_q == IDX_MAX);
        accept   = bus.in_valid && !pending_q;

        cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        pending_d    = pending_q;
        pend_val_d   = pend_val_q;
        pend_mask_d  = pend_mask_q;
        disp_val_d   = disp_val_q;
        disp_mask_d  = disp_mask_q;
        frame_done_d = boundary;
        seg_d        = rom_pat;

        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end

        if (accept) begin
            pending_d   = 1'b1;
            pend_val_d  = bus.in_data;
            pend_mask_d = bus.in_mask;
        end

        if (boundary && pending_q) begin
            pending_d   = 1'b0;
            disp_val_d  = pend_val_q;
            disp_mask_d = pend_mask_q;
        end
    end

    // State registers with synchronous reset; outputs come straight from
    // flops so the digit drivers see no combinational glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            pend_val_q   <= '0;
            pend_mask_q  <= '0;
            disp_val_q   <= '0;
            disp_mask_q  <= '0;
            frame_done_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= BLANK;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_val_q   <= pend_val_d;
            pend_mask_q  <= pend_mask_d;
            disp_val_q   <= disp_val_d;
            disp_mask_q  <= disp_mask_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with DIV=4, NDIG=4 (16-cycle frame).
// Expected values are hand-derived from the hex table and the scan timing.
// Honours LEADING_ZERO_BLANK_EN for the blanking expectations.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   n_cyc;

    seg_scan_ctrl_if #(.NDIG(4)) bus ();

    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_done;

    seg_scan_ctrl #(.DIV(4), .NDIG(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one word; returns 1 unit after the accepting edge.
    task automatic applyStimulus(input logic [15:0] data, input logic [3:0] mask);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_mask  = mask;
        step(1);
        bus.in_valid = 1'b0;
    endtask

    // Step until frame_done is seen (at least one edge), bounded.
    task automatic waitFrame(output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (frame_done !== 1'b1 && cycles < 40);
        if (frame_done !== 1'b1) begin
            checkOutput("frame_timeout", 32'd0, 32'd1);
        end
    endtask

    // Check the anode/segment pair of the slot currently on display.
    task automatic checkSlot(input string tag, input logic [3:0] exp_an,
                             input logic [7:0] exp_seg);
        checkOutput({tag, "_an"}, {28'd0, an}, {28'd0, exp_an});
        checkOutput({tag, "_seg"}, {24'd0, seg}, {24'd0, exp_seg});
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_mask  = '0;

        // Reset state.
        step(3);
        checkOutput("rst_an", {28'd0, an}, 32'hF);
        checkOutput("rst_seg", {24'd0, seg}, 32'hFF);
        checkOutput("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        step(1);
        checkOutput("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // Basic load: first boundary is 16 edges after reset release.
        applyStimulus(16'h12AF, 4'hF);
        checkOutput("ready_after_load", {31'd0, bus.in_ready}, 32'd0);
        waitFrame(n_cyc);
        checkOutput("first_frame_latency", n_cyc, 32'd14);
        step(1);
        checkSlot("load_slot0", 4'b1110, 8'h71);
        step(3);
        checkSlot("slot0_last_cycle", 4'b1110, 8'h71);
        step(1);
        checkSlot("load_slot1", 4'b1101, 8'h11);
        step(4);
        checkSlot("load_slot2", 4'b1011, 8'h25);
        step(4);
        checkSlot("load_slot3", 4'b0111, 8'h9F);

        // Frame rate.
        waitFrame(n_cyc);
        checkOutput("frame_tail", n_cyc, 32'd3);
        waitFrame(n_cyc);
        checkOutput("frame_period", n_cyc, 32'd16);

        // Back-pressure: second word offered while pending is dropped.
        applyStimulus(16'h3456, 4'hF);
        checkOutput("bp_ready_pending", {31'd0, bus.in_ready}, 32'd0);
        applyStimulus(16'h789A, 4'hF);
        checkOutput("bp_still_pending", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("frame_done_width", {31'd0, frame_done}, 32'd0);
        waitFrame(n_cyc);
        step(1);
        checkSlot("bp_slot0", 4'b1110, 8'h41);
        step(4);
        checkSlot("bp_slot1", 4'b1101, 8'h49);

        // Boundary collision: word accepted in the boundary cycle waits a frame.
        step(10);
        applyStimulus(16'hBCDE, 4'hF);
        checkOutput("coll_boundary", {31'd0, frame_done}, 32'd1);
        checkOutput("coll_accepted", {31'd0, bus.in_ready}, 32'd0);
        step(1);
        checkSlot("coll_old_slot0", 4'b1110, 8'h41);
        step(12);
        checkSlot("coll_old_slot3", 4'b0111, 8'h0D);
        waitFrame(n_cyc);
        step(1);
        checkSlot("coll_new_slot0", 4'b1110, 8'h61);
        step(4);
        checkSlot("coll_new_slot1", 4'b1101, 8'h85);

        // Blanking with full mask.
        applyStimulus(16'h0005, 4'hF);
        waitFrame(n_cyc);
        step(1);
        checkSlot("blank_slot0", 4'b1110, 8'h49);
`ifdef LEADING_ZERO_BLANK_EN
        step(4);
        checkSlot("blank_slot1", 4'b1111, 8'hFF);
        step(4);
        checkSlot("blank_slot2", 4'b1111, 8'hFF);
        step(4);
        checkSlot("blank_slot3", 4'b1111, 8'hFF);
`else
        step(4);
        checkSlot("blank_slot1", 4'b1101, 8'h03);
        step(4);
        checkSlot("blank_slot2", 4'b1011, 8'h03);
        step(4);
        checkSlot("blank_slot3", 4'b0111, 8'h03);
`endif

        // Partial mask 4'b0101.
        applyStimulus(16'h0005, 4'b0101);
        waitFrame(n_cyc);
        step(1);
        checkSlot("mask_slot0", 4'b1110, 8'h49);
        step(4);
        checkSlot("mask_slot1", 4'b1111, 8'hFF);
        step(4);
`ifdef LEADING_ZERO_BLANK_EN
        checkSlot("mask_slot2", 4'b1111, 8'hFF);
`else
        checkSlot("mask_slot2", 4'b1011, 8'h03);
`endif
        step(4);
        checkSlot("mask_slot3", 4'b1111, 8'hFF);

        // Reset mid-frame discards the pending word and restarts at idx 0.
        applyStimulus(16'h8888, 4'hF);
        rst = 1'b1;
        step(2);
        checkOutput("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("midrst_an", {28'd0, an}, 32'hF);
        checkOutput("midrst_seg", {24'd0, seg}, 32'hFF);
        checkOutput("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        waitFrame(n_cyc);
        checkOutput("restart_frame", n_cyc, 32'd16);
        step(1);
        checkSlot("restart_slot0", 4'b1111, 8'hFF);
        checkOutput("restart_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000: clk cycles per digit slot, legal range >= 2.
REQ-002 SHALL have parameter NDIG, default 8: number of multiplexed digits, legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: new display word offered.
REQ-006 SHALL have port in_ready, output, 1 bit: high when no pending word exists, i.e. the block can accept.
REQ-007 SHALL have port in_data, input, 4*NDIG bits: hex nibbles, digit k at bits [4k+3:4k].
REQ-008 SHALL have port in_mask, input, NDIG bits: per-digit enable; 0 forces that digit blank.
REQ-009 SHALL have port an, output, NDIG bits: active-low digit select, at most one bit low.
REQ-010 SHALL have port seg, output, 8 bits: active-low segments {a,b,c,d,e,f,g,dp}; 8'hFF = blank.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL count prescaler cnt 0..DIV-1, wrapping to 0; tick = (cnt == DIV-1).
REQ-013 SHALL advance digit index idx by 1 on tick, wrapping NDIG-1 -> 0; frame boundary = tick with idx == NDIG-1.
REQ-014 SHALL register an and seg, so they reflect idx and display state one cycle after those change.
REQ-015 SHALL drive an[idx] = 0 only if disp_mask[idx] = 1 and the digit is not blanked; otherwise an SHALL be all ones.
REQ-016 SHALL drive seg = hex pattern of disp_val nibble idx for a lit digit, else 8'hFF; dp is always 1.
REQ-017 SHALL use these hex patterns (0..F): 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71.
REQ-018 SHALL accept a word on the cycle in_valid && in_ready, capturing in_data/in_mask into pend regs and setting pending.
REQ-019 SHALL hold in_ready = !pending, combinationally from the register.
REQ-020 SHALL copy pend regs to disp_val/disp_mask and clear pending on a frame boundary when pending was already set before that cycle (tear-free update).
REQ-021 SHALL hold a word accepted on a frame-boundary cycle pending until the next frame boundary.
REQ-022 SHALL pulse frame_done high for exactly the cycle after each frame boundary, with or without an update.
REQ-023 SHALL ignore in_valid while pending = 1, leaving the pend regs unchanged.

Reset
REQ-024 SHALL on rst clear cnt, idx, pending, disp_val, disp_mask, pend regs and frame_done to 0, and set an to all ones and seg to 8'hFF.
REQ-025 SHALL let rst mid-frame discard any pending word and restart scanning at idx 0 on the first cycle after rst deasserts.
REQ-026 SHALL hold in_ready = 1 from the first cycle after reset.

Configuration
REQ-027 SHALL, with LEADING_ZERO_BLANK_EN defined, blank every digit above the highest-index nonzero nibble among masked-on digits; digit 0 SHALL never be blanked by this rule.
REQ-028 SHALL, without LEADING_ZERO_BLANK_EN, light every masked-on digit regardless of value.

Structure
REQ-029 SHALL place the 16 hex patterns, the BLANK constant (8'hFF) and the nibble type in shared package seg_pkg.
REQ-030 SHALL contain one sub-module, seg_hex_rom: combinational nibble + enable -> 8-bit active-low pattern, instantiated once.

Verification (bench uses DIV=4, NDIG=4)
REQ-031 SHALL cover reset: after rst, an=4'b1111, seg=FF, in_ready=1 and frame_done=0.
REQ-032 SHALL cover a basic load: load data 16'h12AF, mask 4'hF -> after next boundary, slots 0..3 show seg 71,11,25,9F with an 1110,1101,1011,0111.
REQ-033 SHALL cover the frame rate: frame_done pulses every 16 cycles and each digit slot lasts 4 cycles.
REQ-034 SHALL cover back-pressure: a second load offered while pending -> in_ready=0 and it is dropped; the first word is displayed.
REQ-035 SHALL cover a boundary collision: a load accepted in the boundary cycle -> the old word is shown for one more full frame.
REQ-036 SHALL cover blanking: load 16'h0005, mask F -> with the macro only slot 0 lights (seg 49); without it all slots light (03,03,03,49); mask 4'b0101 -> slots 1 and 3 show an=1111.
